sprite_palette_arbiter: RTL and testbench

Shares one sprite-index ROM (synchronous read) and one palette lookup (combinational, 6-bit index to 12-bit RGB) between two draw requesters, the Fireboy and Watergirl draw units.
- Grants one ROM access per cycle using round-robin arbitration.
- Sequences the read pipeline.
- Returns the registered RGB result, tagged with the requester ID and an opaque flag, to the color mapper.
- Sits between the per-character draw logic and the shared sprite memory/palette.

---
 rtl/sprite_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 39 +++
 rtl/sprite_palette_arbiter.sv | 84 ++++++++
 tb/tb_sprite_palette_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite/palette arbiter slice.
// Requester IDs, RGB width and the packed 12-bit color type.
package sprite_pkg;

  localparam int RGB_W = 12;

  localparam logic ID_BOY  = 1'b0;
  localparam logic ID_GIRL = 1'b1;

  typedef logic [RGB_W-1:0] rgb12_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with its rr_last history register.
// Ports: clk, rst, req[1:0], flush in; gnt[1:0] one-hot out (combinational).
module rr_arbiter2
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       flush,
  output logic [1:0] gnt
);

  logic rr_last;
  logic xfer;

  // rr_last names the previous winner; on contention the other side wins.
  always_comb begin
    gnt = 2'b00;
    if (!flush) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (rr_last == ID_BOY) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign xfer = |(req & gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= ID_GIRL;
    end else if (xfer) begin
      rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Shares one sync sprite ROM and a comb palette between two draw units.
// Ports: req/addr0/addr1 -> gnt; rom_addr/rom_index; pal_index/pal_rgb; rsp_*.
module sprite_palette_arbiter
  import sprite_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int IDX_W        = 6,
  parameter int ROM_LAT      = 1,
  parameter int TRANSP_INDEX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        gnt,
  input  logic              flush,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_index,
  output logic [IDX_W-1:0]  pal_index,
  input  rgb12_t            pal_rgb,
  output logic              rsp_valid,
  output logic              rsp_id,
  output rgb12_t            rsp_rgb,
  output logic              rsp_opaque
);

  logic             xfer;
  logic             gid;
  logic [ROM_LAT:0] vld;
  logic [ROM_LAT:0] ids;
  logic             hit;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .flush (flush),
    .gnt   (gnt)
  );

  assign xfer      = |(req & gnt);
  assign gid       = gnt[1];
  assign pal_index = rom_index;

  // Stage ROM_LAT lines up with rom_index for the access it tags.
  assign hit = vld[ROM_LAT] & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      vld      <= '0;
      ids      <= '0;
    end else begin
      if (xfer) begin
        rom_addr <= gid ? addr1 : addr0;
      end
      if (flush) begin
        vld <= '0;
      end else begin
        vld <= {vld[ROM_LAT-1:0], xfer};
      end
      ids <= {ids[ROM_LAT-1:0], gid};
    end
  end

  // Response data only moves on a live response, so a flush leaves it held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= ID_BOY;
      rsp_rgb    <= '0;
      rsp_opaque <= 1'b0;
    end else begin
      rsp_valid <= hit;
      if (hit) begin
        rsp_id     <= ids[ROM_LAT];
        rsp_rgb    <= pal_rgb;
        rsp_opaque <= (rom_index != IDX_W'(TRANSP_INDEX));
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed bench for sprite_palette_arbiter (ROM_LAT=1 and ROM_LAT=2).
// ROM and palette are small behavioural models owned by the bench.
module tb_sprite_palette_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [9:0]  addr0 = '0;
  logic [9:0]  addr1 = '0;
  logic        flush = 1'b0;

  logic [1:0]  gnt_a, gnt_b;
  logic [9:0]  rom_addr_a, rom_addr_b;
  logic [5:0]  rom_index_a, rom_index_b;
  logic [5:0]  pal_index_a, pal_index_b;
  logic [11:0] pal_rgb_a, pal_rgb_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic        rsp_id_a, rsp_id_b;
  logic [11:0] rsp_rgb_a, rsp_rgb_b;
  logic        rsp_opaque_a, rsp_opaque_b;

  logic [5:0]  r1a, r1b, r2b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] rom_f(input logic [9:0] a);
    if (a == 10'h155) return 6'd5;
    return a[5:0];
  endfunction

  function automatic logic [11:0] pal_f(input logic [5:0] i);
    if (i == 6'd0) return 12'h79A;
    if (i == 6'd5) return 12'h578;
    return {i, i};
  endfunction

  always_ff @(posedge clk) begin
    r1a <= rom_f(rom_addr_a);
    r1b <= rom_f(rom_addr_b);
    r2b <= r1b;
  end

  assign rom_index_a = r1a;
  assign rom_index_b = r2b;
  assign pal_rgb_a   = pal_f(pal_index_a);
  assign pal_rgb_b   = pal_f(pal_index_b);

  sprite_palette_arbiter #(.ROM_LAT(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .addr0      (addr0),
    .addr1      (addr1),
    .gnt        (gnt_a),
    .flush      (flush),
    .rom_addr   (rom_addr_a),
    .rom_index  (rom_index_a),
    .pal_index  (pal_index_a),
    .pal_rgb    (pal_rgb_a),
    .rsp_valid  (rsp_valid_a),
    .rsp_id     (rsp_id_a),
    .rsp_rgb    (rsp_rgb_a),
    .rsp_opaque (rsp_opaque_a)
  );

  sprite_palette_arbiter #(.ROM_LAT(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .addr0      (addr0),
    .addr1      (addr1),
    .gnt        (gnt_b),
    .flush      (flush),
    .rom_addr   (rom_addr_b),
    .rom_index  (rom_index_b),
    .pal_index  (pal_index_b),
    .pal_rgb    (pal_rgb_b),
    .rsp_valid  (rsp_valid_b),
    .rsp_id     (rsp_id_b),
    .rsp_rgb    (rsp_rgb_b),
    .rsp_opaque (rsp_opaque_b)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rom_addr_a !== 10'h0) begin
      n_bad++;
      $display("FAIL reset_rom_addr got %h want 000", rom_addr_a);
    end
    n_cmp++;
    if ({rsp_valid_a, rsp_id_a, rsp_opaque_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000",
               {rsp_valid_a, rsp_id_a, rsp_opaque_a});
    end
    n_cmp++;
    if (rsp_rgb_a !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_rgb got %h want 000", rsp_rgb_a);
    end
    n_cmp++;
    if (gnt_a !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_gnt got %b want 00", gnt_a);
    end
    rst = 1'b0;
  endtask

  // Iteration k samples at the negedge before edge N0+k; a transfer
  // at edge N0+i shows its response at iteration i+3.
  task automatic test_contention();
    logic [1:0] eg;
    logic ev, eid;
    logic [11:0] ergb;
    @(negedge clk);
    addr0 = 10'h101;
    addr1 = 10'h202;
    for (int k = 0; k < 10; k++) begin
      req = (k < 6) ? 2'b11 : 2'b00;
      #1;
      if (k < 6) begin
        eg = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++;
        if (gnt_a !== eg) begin
          n_bad++;
          $display("FAIL contend_gnt k=%0d got %b want %b", k, gnt_a, eg);
        end
      end
      ev = (k >= 3 && k <= 8);
      n_cmp++;
      if (rsp_valid_a !== ev) begin
        n_bad++;
        $display("FAIL contend_valid k=%0d got %b want %b", k, rsp_valid_a, ev);
      end
      if (ev) begin
        eid  = ((k - 3) % 2 == 1);
        ergb = eid ? 12'h082 : 12'h041;
        n_cmp++;
        if (rsp_id_a !== eid) begin
          n_bad++;
          $display("FAIL contend_id k=%0d got %b want %b", k, rsp_id_a, eid);
        end
        n_cmp++;
        if (rsp_rgb_a !== ergb) begin
          n_bad++;
          $display("FAIL contend_rgb k=%0d got %h want %h", k, rsp_rgb_a, ergb);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    addr0 = 10'h155;
    for (int k = 0; k < 5; k++) begin
      req = (k == 0) ? 2'b01 : 2'b00;
      #1;
      if (k == 0) begin
        n_cmp++;
        if (gnt_a !== 2'b01) begin
          n_bad++;
          $display("FAIL single_gnt got %b want 01", gnt_a);
        end
      end
      if (k == 1) begin
        n_cmp++;
        if (rom_addr_a !== 10'h155) begin
          n_bad++;
          $display("FAIL single_rom_addr got %h want 155", rom_addr_a);
        end
      end
      n_cmp++;
      if (rsp_valid_a !== (k == 3)) begin
        n_bad++;
        $display("FAIL single_valid k=%0d got %b", k, rsp_valid_a);
      end
      if (k == 3) begin
        n_cmp++;
        if ({rsp_id_a, rsp_opaque_a, rsp_rgb_a} !== {1'b0, 1'b1, 12'h578}) begin
          n_bad++;
          $display("FAIL single_rsp got id=%b op=%b rgb=%h want 0 1 578",
                   rsp_id_a, rsp_opaque_a, rsp_rgb_a);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_transparent();
    addr1 = 10'h040;
    for (int k = 0; k < 5; k++) begin
      req = (k == 0) ? 2'b10 : 2'b00;
      #1;
      if (k == 0) begin
        n_cmp++;
        if (gnt_a !== 2'b10) begin
          n_bad++;
          $display("FAIL transp_gnt got %b want 10", gnt_a);
        end
      end
      n_cmp++;
      if (rsp_valid_a !== (k == 3)) begin
        n_bad++;
        $display("FAIL transp_valid k=%0d got %b", k, rsp_valid_a);
      end
      if (k == 3) begin
        n_cmp++;
        if ({rsp_id_a, rsp_opaque_a, rsp_rgb_a} !== {1'b1, 1'b0, 12'h79A}) begin
          n_bad++;
          $display("FAIL transp_rsp got id=%b op=%b rgb=%h want 1 0 79a",
                   rsp_id_a, rsp_opaque_a, rsp_rgb_a);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    addr0 = 10'h101;
    addr1 = 10'h202;
    for (int k = 0; k < 9; k++) begin
      req   = (k <= 2 || k == 4) ? 2'b11 : 2'b00;
      flush = (k == 2);
      #1;
      if (k == 1) begin
        n_cmp++;
        if (gnt_a !== 2'b10) begin
          n_bad++;
          $display("FAIL flush_gnt1 got %b want 10", gnt_a);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (gnt_a !== 2'b00) begin
          n_bad++;
          $display("FAIL flush_gnt_block got %b want 00", gnt_a);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (gnt_a !== 2'b01) begin
          n_bad++;
          $display("FAIL flush_gnt_after got %b want 01", gnt_a);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (rsp_rgb_a !== 12'h79A) begin
          n_bad++;
          $display("FAIL flush_hold_rgb got %h want 79a", rsp_rgb_a);
        end
      end
      n_cmp++;
      if (rsp_valid_a !== (k == 7)) begin
        n_bad++;
        $display("FAIL flush_valid k=%0d got %b", k, rsp_valid_a);
      end
      if (k == 7) begin
        n_cmp++;
        if ({rsp_id_a, rsp_rgb_a} !== {1'b0, 12'h041}) begin
          n_bad++;
          $display("FAIL flush_rsp got id=%b rgb=%h want 0 041",
                   rsp_id_a, rsp_rgb_a);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    req = 2'b11;
    #1;
    n_cmp++;
    if (gnt_a !== 2'b10) begin
      n_bad++;
      $display("FAIL rmid_gnt0 got %b want 10", gnt_a);
    end
    repeat (2) @(negedge clk);
    req = 2'b00;
    #1;
    n_cmp++;
    if (rom_addr_a !== 10'h101) begin
      n_bad++;
      $display("FAIL rmid_pre_addr got %h want 101", rom_addr_a);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rom_addr_a, rsp_rgb_a} !== 22'h0) begin
      n_bad++;
      $display("FAIL rmid_async_data got addr=%h rgb=%h want 0",
               rom_addr_a, rsp_rgb_a);
    end
    n_cmp++;
    if ({rsp_valid_a, rsp_id_a, rsp_opaque_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL rmid_async_flags got %b want 000",
               {rsp_valid_a, rsp_id_a, rsp_opaque_a});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({rsp_valid_a, rsp_valid_b} !== 2'b00) begin
        n_bad++;
        $display("FAIL rmid_no_rsp k=%0d got %b want 00",
                 k, {rsp_valid_a, rsp_valid_b});
      end
      @(negedge clk);
    end
    req = 2'b11;
    #1;
    n_cmp++;
    if (gnt_a !== 2'b01) begin
      n_bad++;
      $display("FAIL rmid_first_gnt got %b want 01", gnt_a);
    end
    @(negedge clk);
    req = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_lat2();
    addr0 = 10'h155;
    for (int k = 0; k < 6; k++) begin
      req = (k == 0) ? 2'b01 : 2'b00;
      #1;
      if (k == 0) begin
        n_cmp++;
        if (gnt_b !== 2'b01) begin
          n_bad++;
          $display("FAIL lat2_gnt got %b want 01", gnt_b);
        end
      end
      n_cmp++;
      if (rsp_valid_b !== (k == 4)) begin
        n_bad++;
        $display("FAIL lat2_valid k=%0d got %b", k, rsp_valid_b);
      end
      if (k == 4) begin
        n_cmp++;
        if ({rsp_id_b, rsp_opaque_b, rsp_rgb_b} !== {1'b0, 1'b1, 12'h578}) begin
          n_bad++;
          $display("FAIL lat2_rsp got id=%b op=%b rgb=%h want 0 1 578",
                   rsp_id_b, rsp_opaque_b, rsp_rgb_b);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_transparent();
    test_flush();
    test_reset_mid();
    test_lat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
